// File: rtl/divide_pkg.sv
// Shared widths, latency and saturation limits for the pipelined signed/unsigned divider.
package divide_pkg;

  localparam int DIV_DVD_W = 19;
  localparam int DIV_DVS_W = 8;
  localparam int DIV_QUO_W = 11;
  localparam int LATENCY   = 12;
  localparam int QMAX      = 1023;
  localparam int QMIN      = -1024;

  // Magnitude padded to an even width so ten 2-bit stages consume it exactly.
  localparam int NUM_W  = DIV_DVD_W + 1;
  localparam int N_STEP = NUM_W / 2;

  // num starts as the magnitude and ends as the quotient, one bit shifted per iteration.
  typedef struct packed {
    logic                 vld;
    logic                 sgn;
    logic [DIV_DVS_W-1:0] dvs;
    logic [DIV_DVS_W-1:0] rem;
    logic [NUM_W-1:0]     num;
  } stage_t;

  typedef struct packed {
    logic           vld;
    logic           sgn;
    logic [NUM_W:0] qr;
  } round_t;

endpackage

// File: rtl/divide_div_step2.sv
// Two unsigned restoring-division iterations; purely combinational.
module div_step2
  import divide_pkg::*;
(
  input  logic [DIV_DVS_W-1:0] dvs,
  input  logic [DIV_DVS_W-1:0] rem_in,
  input  logic [NUM_W-1:0]     num_in,
  output logic [DIV_DVS_W-1:0] rem_out,
  output logic [NUM_W-1:0]     num_out
);

  logic [DIV_DVS_W:0]   trial;
  logic [DIV_DVS_W-1:0] rem;
  logic [NUM_W-1:0]     num;

  always_comb begin
    rem   = rem_in;
    num   = num_in;
    trial = '0;
    for (int i = 0; i < 2; i++) begin
      trial = {rem, num[NUM_W-1]};
      if (trial >= {1'b0, dvs}) begin
        trial = trial - {1'b0, dvs};
        num   = {num[NUM_W-2:0], 1'b1};
      end else begin
        num   = {num[NUM_W-2:0], 1'b0};
      end
      rem = trial[DIV_DVS_W-1:0];
    end
    rem_out = rem;
    num_out = num;
  end

endmodule

// File: rtl/divide.sv
// Fully pipelined s19 / u8 divider with round-half-away and s11 saturation.
// Latency 12 cycles, one operand pair per cycle, no backpressure.
module divide
  import divide_pkg::*;
#(
  parameter int DVD_W = DIV_DVD_W,
  parameter int DVS_W = DIV_DVS_W,
  parameter int QUO_W = DIV_QUO_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  input  logic             div_in_valid,
  output logic [QUO_W-1:0] quotient,
  output logic             div_out_valid
);

  stage_t               pipe_d [N_STEP+1];
  stage_t               pipe_q [N_STEP+1];
  logic [DIV_DVS_W-1:0] step_rem [N_STEP+1];
  logic [NUM_W-1:0]     step_num [N_STEP+1];
  round_t               round_d, round_q;
  logic [QUO_W-1:0]     quotient_d, quotient_q;
  logic                 out_vld_d, out_vld_q;
  logic [DVD_W-1:0]     mag;

  assign step_rem[0] = '0;
  assign step_num[0] = '0;

  for (genvar k = 1; k <= N_STEP; k++) begin : g_step
    div_step2 u_step (
      .dvs     (pipe_q[k-1].dvs),
      .rem_in  (pipe_q[k-1].rem),
      .num_in  (pipe_q[k-1].num),
      .rem_out (step_rem[k]),
      .num_out (step_num[k])
    );
  end

  // Two's-complement negate in DVD_W bits maps -2^18 to 2^18, which fits unsigned.
  assign mag = dividend[DVD_W-1] ? (-dividend) : dividend;

  always_comb begin
    pipe_d[0]     = pipe_q[0];
    pipe_d[0].vld = div_in_valid;
    if (div_in_valid) begin
      pipe_d[0].sgn = dividend[DVD_W-1];
      pipe_d[0].dvs = divisor;
      pipe_d[0].rem = '0;
      pipe_d[0].num = {1'b0, mag};
    end
    for (int k = 1; k <= N_STEP; k++) begin
      pipe_d[k].vld = pipe_q[k-1].vld;
      pipe_d[k].sgn = pipe_q[k-1].sgn;
      pipe_d[k].dvs = pipe_q[k-1].dvs;
      pipe_d[k].rem = step_rem[k];
      pipe_d[k].num = step_num[k];
    end
  end

  always_comb begin
    round_d.vld = pipe_q[N_STEP].vld;
    round_d.sgn = pipe_q[N_STEP].sgn;
    if (pipe_q[N_STEP].dvs == '0) begin
      round_d.qr = '0;
    end else if ({pipe_q[N_STEP].rem, 1'b0} >= {1'b0, pipe_q[N_STEP].dvs}) begin
      round_d.qr = {1'b0, pipe_q[N_STEP].num} + (NUM_W+1)'(1);
    end else begin
      round_d.qr = {1'b0, pipe_q[N_STEP].num};
    end
  end

  always_comb begin
    out_vld_d  = round_q.vld;
    quotient_d = quotient_q;
    if (round_q.vld) begin
      if (!round_q.sgn) begin
        quotient_d = (round_q.qr > (NUM_W+1)'(QMAX)) ? QUO_W'(QMAX) : round_q.qr[QUO_W-1:0];
      end else begin
        // Magnitude 0 negates to 0, so no negative-zero encoding can appear.
        quotient_d = (round_q.qr > (NUM_W+1)'(-QMIN)) ? QUO_W'(QMIN) : -round_q.qr[QUO_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k <= N_STEP; k++) pipe_q[k] <= '0;
      round_q    <= '0;
      quotient_q <= '0;
      out_vld_q  <= 1'b0;
    end else begin
      for (int k = 0; k <= N_STEP; k++) pipe_q[k] <= pipe_d[k];
      round_q    <= round_d;
      quotient_q <= quotient_d;
      out_vld_q  <= out_vld_d;
    end
  end

  assign quotient      = quotient_q;
  assign div_out_valid = out_vld_q;

endmodule

// File: tb/tb_divide.sv
// Random and directed stimulus for divide, checked against an integer-arithmetic reference.
module tb_divide;
  import divide_pkg::*;

  logic               clk;
  logic               rstn;
  logic signed [18:0] dividend;
  logic [7:0]         divisor;
  logic               div_in_valid;
  logic [10:0]        quotient;
  logic               div_out_valid;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int cur_exp = 0;
  int last_q  = 0;
  bit checking = 0;
  bit exp_v [0:2047];
  int exp_q [0:2047];

  divide dut (
    .clk           (clk),
    .rstn          (rstn),
    .dividend      (dividend),
    .divisor       (divisor),
    .div_in_valid  (div_in_valid),
    .quotient      (quotient),
    .div_out_valid (div_out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int ref_div(input int dd, input int dv);
    int mag, q, r, res;
    if (dv == 0) return 0;
    mag = (dd < 0) ? -dd : dd;
    q = mag / dv;
    r = mag % dv;
    if (2 * r >= dv) q++;
    res = (dd < 0) ? -q : q;
    if (res > QMAX) res = QMAX;
    if (res < QMIN) res = QMIN;
    return res;
  endfunction

  // Record the expected result for every sampled pair, LATENCY edges ahead.
  always @(posedge clk) begin
    cyc++;
    if (rstn && div_in_valid && (cyc + LATENCY) < 2048) begin
      exp_v[cyc + LATENCY] = 1'b1;
      exp_q[cyc + LATENCY] = cur_exp;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      if (!rstn) begin
        check("rst_vld", int'(div_out_valid), 0);
        check("rst_quo", int'($signed(quotient)), 0);
        last_q = 0;
        for (int i = 0; i <= LATENCY + 2; i++)
          if (cyc + i < 2048) exp_v[cyc + i] = 1'b0;
      end else begin
        check("out_vld", int'(div_out_valid), int'(exp_v[cyc]));
        if (exp_v[cyc]) begin
          check("quo", int'($signed(quotient)), exp_q[cyc]);
          last_q = exp_q[cyc];
        end else begin
          check("hold", int'($signed(quotient)), last_q);
        end
      end
    end
  end

  task automatic drive(input bit vld, input int dd, input int dv, input int exp);
    @(posedge clk);
    #1;
    div_in_valid = vld;
    dividend     = 19'(dd);
    divisor      = 8'(dv);
    cur_exp      = exp;
  endtask

  task automatic send_rand();
    int dd, dv;
    logic signed [18:0] d19;
    d19 = 19'($urandom_range(0, 524287));
    case ($urandom_range(0, 7))
      0: d19 = 19'sh3FFFF;
      1: d19 = 19'sh40000;
      default: ;
    endcase
    dd = int'(d19);
    dv = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 255);
    drive(1'b1, dd, dv, ref_div(dd, dv));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, int'($urandom_range(0, 1000)), 3, 0);
  endtask

  initial begin
    rstn = 1'b1;
    div_in_valid = 1'b0;
    dividend = '0;
    divisor = '0;
    #1 rstn = 1'b0;
    checking = 1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    drive(1'b1, 100, 16, 6);
    drive(1'b1, 24, 16, 2);
    drive(1'b1, 23, 16, 1);
    drive(1'b1, -24, 16, -2);
    drive(1'b1, -23, 16, -1);
    drive(1'b1, -7, 16, 0);
    drive(1'b1, 262143, 1, 1023);
    drive(1'b1, -262144, 1, -1024);
    drive(1'b1, 1024, 1, 1023);
    drive(1'b1, -1024, 1, -1024);
    drive(1'b1, 255, 255, 1);
    idle(2);
    drive(1'b1, 500, 0, 0);
    drive(1'b1, -9, 6, -2);
    idle(LATENCY + 3);

    for (int i = 0; i < 64; i++) send_rand();
    idle(LATENCY + 2);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 2) == 0) idle(1);
      else send_rand();
    end
    idle(LATENCY + 2);

    for (int i = 0; i < 6; i++) send_rand();
    #1 rstn = 1'b0;
    for (int i = 0; i < 3; i++) send_rand();
    #1 rstn = 1'b1;
    for (int i = 0; i < 20; i++) send_rand();
    idle(LATENCY + 4);

    checking = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
